// File: rtl/pyth_pkg.sv
// Shared constants and FSM state encoding for the Pythagorean engines.
package pyth_pkg;

  localparam int unsigned WIDTH = 8;

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StIter,
    StDone
  } state_e;

endpackage

// File: rtl/pyth_leg_solver_if.sv
// Request/response bundle for pyth_leg_solver; rem_out exists only with PYTH_LEG_REMAINDER_EN.
interface pyth_leg_solver_if
  import pyth_pkg::*;
#(
  parameter int unsigned Width = WIDTH
);

  logic               start;
  logic [Width-1:0]   hyp;
  logic [Width-1:0]   leg_in;
  logic               ready;
  logic               out_valid;
  logic [Width-1:0]   leg_out;
  logic               err;
`ifdef PYTH_LEG_REMAINDER_EN
  logic [2*Width-1:0] rem_out;
`endif

  modport master (
    output start, hyp, leg_in,
`ifdef PYTH_LEG_REMAINDER_EN
    input  rem_out,
`endif
    input  ready, out_valid, leg_out, err
  );

  modport slave (
    input  start, hyp, leg_in,
`ifdef PYTH_LEG_REMAINDER_EN
    output rem_out,
`endif
    output ready, out_valid, leg_out, err
  );

endinterface

// File: rtl/pyth_isqrt_step.sv
// One bit of restoring integer square root: keep bit idx_i if the trial square still fits.
module pyth_isqrt_step #(
  parameter int unsigned Width = 8,
  parameter int unsigned IdxW  = 3
) (
  input  logic [Width-1:0]   root_i,
  input  logic [IdxW-1:0]    idx_i,
  input  logic [2*Width-1:0] diff_i,
  output logic [Width-1:0]   root_o
);

  logic [Width-1:0]   trial;
  logic [2*Width-1:0] trial_sq;

  always_comb begin
    trial    = root_i | (Width'(1) << idx_i);
    trial_sq = {{Width{1'b0}}, trial} * {{Width{1'b0}}, trial};
    root_o   = (trial_sq <= diff_i) ? trial : root_i;
  end

endmodule

// File: rtl/pyth_leg_solver.sv
// Multi-cycle B = floor(sqrt(C*C - A*A)); define PYTH_LEG_REMAINDER_EN to expose the remainder.
module pyth_leg_solver
  import pyth_pkg::*;
#(
  parameter int unsigned Width = WIDTH
) (
  input logic              clk,
  input logic              rst,
  pyth_leg_solver_if.slave bus
);

  localparam int unsigned IdxW = (Width > 1) ? $clog2(Width) : 1;

  state_e               state_q;
  logic [Width-1:0]     hyp_q;
  logic [Width-1:0]     leg_q;
  logic [2*Width-1:0]   diff_q;
  logic [Width-1:0]     root_q;
  logic [IdxW-1:0]      idx_q;
  logic                 out_valid_q;
  logic [Width-1:0]     leg_out_q;
  logic                 err_q;

  logic [2*Width-1:0]   hyp_sq;
  logic [2*Width-1:0]   leg_sq;
  logic [Width-1:0]     root_d;

  always_comb begin
    hyp_sq = {{Width{1'b0}}, hyp_q} * {{Width{1'b0}}, hyp_q};
    leg_sq = {{Width{1'b0}}, leg_q} * {{Width{1'b0}}, leg_q};
  end

  pyth_isqrt_step #(
    .Width (Width),
    .IdxW  (IdxW)
  ) u_step (
    .root_i (root_q),
    .idx_i  (idx_q),
    .diff_i (diff_q),
    .root_o (root_d)
  );

`ifdef PYTH_LEG_REMAINDER_EN
  logic [2*Width-1:0] rem_q;
  logic [2*Width-1:0] root_sq;

  always_comb root_sq = {{Width{1'b0}}, root_q} * {{Width{1'b0}}, root_q};

  always_ff @(posedge clk) begin
    if (rst) begin
      rem_q <= '0;
    end else if (state_q == StDone) begin
      rem_q <= err_q ? '0 : (diff_q - root_sq);
    end
  end

  assign bus.rem_out = rem_q;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      hyp_q       <= '0;
      leg_q       <= '0;
      diff_q      <= '0;
      root_q      <= '0;
      idx_q       <= '0;
      out_valid_q <= 1'b0;
      leg_out_q   <= '0;
      err_q       <= 1'b0;
    end else begin
      out_valid_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (bus.start) begin
            hyp_q   <= bus.hyp;
            leg_q   <= bus.leg_in;
            state_q <= StLoad;
          end
        end
        StLoad: begin
          if (leg_q > hyp_q) begin
            err_q     <= 1'b1;
            leg_out_q <= '0;
            state_q   <= StDone;
          end else begin
            // A <= C guarantees the difference is non-negative.
            diff_q  <= hyp_sq - leg_sq;
            root_q  <= '0;
            idx_q   <= IdxW'(Width - 1);
            err_q   <= 1'b0;
            state_q <= StIter;
          end
        end
        StIter: begin
          root_q <= root_d;
          if (idx_q == '0) begin
            state_q <= StDone;
          end else begin
            idx_q <= idx_q - 1'b1;
          end
        end
        StDone: begin
          leg_out_q   <= err_q ? '0 : root_q;
          out_valid_q <= 1'b1;
          state_q     <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.ready     = (state_q == StIdle);
  assign bus.out_valid = out_valid_q;
  assign bus.leg_out   = leg_out_q;
  assign bus.err       = err_q;

endmodule

// File: tb/tb_pyth_leg_solver.sv
// Directed self-checking bench for pyth_leg_solver (WIDTH=8).
module tb_pyth_leg_solver;

  localparam int unsigned W = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;

  pyth_leg_solver_if #(.Width(W)) bus ();

  pyth_leg_solver #(.Width(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Issue one request and wait for its result; lat counts edges after the accepting edge.
  task automatic do_op(input logic [W-1:0] c, input logic [W-1:0] a,
                       output logic [W-1:0] leg, output logic e,
                       output logic [2*W-1:0] rem, output int lat);
    @(negedge clk);
    bus.start  = 1'b1;
    bus.hyp    = c;
    bus.leg_in = a;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    lat = 0;
    while (bus.out_valid !== 1'b1 && lat < 40) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    if (lat >= 40) begin
      checks++;
      failures++;
      $display("FAIL timeout c=%0d a=%0d got no out_valid within 40 cycles", c, a);
    end
    leg = bus.leg_out;
    e   = bus.err;
`ifdef PYTH_LEG_REMAINDER_EN
    rem = bus.rem_out;
`else
    rem = '0;
`endif
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.start = 1'b0;
    bus.hyp = '0;
    bus.leg_in = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (bus.ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", bus.ready); end
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", bus.out_valid); end
    checks++; if (bus.leg_out !== 8'd0) begin failures++; $display("FAIL reset_leg got=%0d exp=0", bus.leg_out); end
    checks++; if (bus.err !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", bus.err); end
`ifdef PYTH_LEG_REMAINDER_EN
    checks++; if (bus.rem_out !== 16'd0) begin failures++; $display("FAIL reset_rem got=%0d exp=0", bus.rem_out); end
`endif
    rst = 1'b0;
  endtask

  task automatic test_basic();
    logic [W-1:0] leg; logic e; logic [2*W-1:0] rem; int lat;
    do_op(8'd5, 8'd3, leg, e, rem, lat);
    checks++; if (leg !== 8'd4) begin failures++; $display("FAIL c5a3_leg got=%0d exp=4", leg); end
    checks++; if (e !== 1'b0) begin failures++; $display("FAIL c5a3_err got=%b exp=0", e); end
    checks++; if (lat !== 10) begin failures++; $display("FAIL c5a3_latency got=%0d exp=10", lat); end
`ifdef PYTH_LEG_REMAINDER_EN
    checks++; if (rem !== 16'd0) begin failures++; $display("FAIL c5a3_rem got=%0d exp=0", rem); end
`endif
    do_op(8'd200, 8'd100, leg, e, rem, lat);
    checks++; if (leg !== 8'd173) begin failures++; $display("FAIL c200a100_leg got=%0d exp=173", leg); end
    checks++; if (e !== 1'b0) begin failures++; $display("FAIL c200a100_err got=%b exp=0", e); end
`ifdef PYTH_LEG_REMAINDER_EN
    checks++; if (rem !== 16'd71) begin failures++; $display("FAIL c200a100_rem got=%0d exp=71", rem); end
`endif
  endtask

  task automatic test_boundaries();
    logic [W-1:0] leg; logic e; logic [2*W-1:0] rem; int lat;
    do_op(8'd255, 8'd0, leg, e, rem, lat);
    checks++; if (leg !== 8'd255) begin failures++; $display("FAIL c255a0_leg got=%0d exp=255", leg); end
    do_op(8'd10, 8'd10, leg, e, rem, lat);
    checks++; if (leg !== 8'd0) begin failures++; $display("FAIL c10a10_leg got=%0d exp=0", leg); end
    checks++; if (e !== 1'b0) begin failures++; $display("FAIL c10a10_err got=%b exp=0", e); end
    do_op(8'd0, 8'd0, leg, e, rem, lat);
    checks++; if (leg !== 8'd0) begin failures++; $display("FAIL c0a0_leg got=%0d exp=0", leg); end
    checks++; if (e !== 1'b0) begin failures++; $display("FAIL c0a0_err got=%b exp=0", e); end
  endtask

  task automatic test_err();
    logic [W-1:0] leg; logic e; logic [2*W-1:0] rem; int lat;
    do_op(8'd13, 8'd5, leg, e, rem, lat);  // leaves a non-zero leg_out behind
    do_op(8'd3, 8'd5, leg, e, rem, lat);
    checks++; if (e !== 1'b1) begin failures++; $display("FAIL c3a5_err got=%b exp=1", e); end
    checks++; if (leg !== 8'd0) begin failures++; $display("FAIL c3a5_leg got=%0d exp=0", leg); end
    checks++; if (lat !== 2) begin failures++; $display("FAIL c3a5_latency got=%0d exp=2", lat); end
    @(negedge clk);
    checks++; if (bus.err !== 1'b1) begin failures++; $display("FAIL c3a5_err_held got=%b exp=1", bus.err); end
  endtask

  task automatic test_ignore_busy();
    int pulses = 0;
    logic [W-1:0] first_leg = '0;
    @(negedge clk);
    bus.start = 1'b1; bus.hyp = 8'd200; bus.leg_in = 8'd100;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (bus.ready !== 1'b0) begin failures++; $display("FAIL busy_ready got=%b exp=0", bus.ready); end
    bus.start = 1'b1; bus.hyp = 8'd5; bus.leg_in = 8'd3;
    @(negedge clk);
    bus.start = 1'b0; bus.hyp = 8'd0; bus.leg_in = 8'd0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (bus.out_valid === 1'b1) begin
        if (pulses == 0) first_leg = bus.leg_out;
        pulses++;
      end
    end
    checks++; if (pulses !== 1) begin failures++; $display("FAIL busy_pulses got=%0d exp=1", pulses); end
    checks++; if (first_leg !== 8'd173) begin failures++; $display("FAIL busy_leg got=%0d exp=173", first_leg); end
  endtask

  task automatic test_reset_mid();
    logic [W-1:0] leg; logic e; logic [2*W-1:0] rem; int lat;
    int pulses = 0;
    @(negedge clk);
    bus.start = 1'b1; bus.hyp = 8'd200; bus.leg_in = 8'd100;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++; if (bus.ready !== 1'b1) begin failures++; $display("FAIL midrst_ready got=%b exp=1", bus.ready); end
    checks++; if (bus.leg_out !== 8'd0) begin failures++; $display("FAIL midrst_leg got=%0d exp=0", bus.leg_out); end
    checks++; if (bus.err !== 1'b0) begin failures++; $display("FAIL midrst_err got=%b exp=0", bus.err); end
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      if (bus.out_valid === 1'b1) pulses++;
    end
    checks++; if (pulses !== 0) begin failures++; $display("FAIL midrst_pulses got=%0d exp=0", pulses); end
    do_op(8'd13, 8'd5, leg, e, rem, lat);
    checks++; if (leg !== 8'd12) begin failures++; $display("FAIL midrst_c13a5_leg got=%0d exp=12", leg); end
    checks++; if (lat !== 10) begin failures++; $display("FAIL midrst_latency got=%0d exp=10", lat); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_boundaries();
    test_err();
    test_ignore_busy();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
